dcache_param: RTL and testbench
===============================

# dcache_param

Parametrised direct-mapped, write-back, write-allocate data cache between the CPU data port and a word-serial memory port. It is the generalised successor of the fixed Dcache exercised by the cache bench. Line count and line length are parameters. It adds byte-enable writes, dirty-line write-back, a whole-cache flush, and hit/miss counters. Arrays are register-based with asynchronous read.

## Interface
- INDEX_W, 6: index bits; SETS = 2^INDEX_W lines.
- OFFSET_W, 2: word-offset bits; LINE = 2^OFFSET_W 32-bit words per line.
- Tag width = 30 - INDEX_W - OFFSET_W. Address split: [1:0] byte, [OFFSET_W+1:2] word, next INDEX_W bits index, remainder tag.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid; held with addr/we/sel/wdata stable until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_sel  in  4  byte enables for writes (bit i = byte i).
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- flush  in  1  flush request pulse.
- busy  out  1  high from miss/flush start until return to IDLE.
- flush_done  out  1  one-cycle pulse at flush end.
- mem_req, mem_we  out  1  memory word request / write.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  write-back data.
- mem_rdata  in  32  refill data, sampled on mem_ack.
- mem_ack  in  1  one-cycle word completion.
- hit_cnt, miss_cnt  out  32  saturating counters (stop at 0xFFFFFFFF).

## Operation
- States: IDLE, WB, REFILL, FLUSH.
- IDLE, cpu_req=1 and cpu_ready=0 (the ready cycle ignores the still-held request):
  - Hit = valid[index] and tag match.
  - Read hit: register word into cpu_rdata; pulse cpu_ready next cycle.
  - Write hit: merge bytes per cpu_sel; set dirty; pulse cpu_ready next cycle.
  - Each hit increments hit_cnt.
- Miss: increment miss_cnt once, at detection.
  - Victim valid and dirty: go to WB.
  - Otherwise go to REFILL.
  - After REFILL, return to IDLE. The re-lookup hits but does not increment hit_cnt.
- WB: write LINE words, word 0 first. mem_addr = {victim_tag, index, word, 2'b00}, mem_we=1. Then go to REFILL.
- REFILL: read LINE words from line base {tag, index, 0, 2'b00}, word 0 first. Each ack writes mem_rdata into the data array. At end, set valid, clear dirty, install the new tag.
- Memory handshake:
  - mem_req stays high with stable addr/we/wdata until mem_ack.
  - The cycle after an ack presents the next word, or drops mem_req after the last word.
  - Ack is permitted in the first cycle of mem_req.
- FLUSH:
  - Accepted in IDLE when flush=1 and no CPU request is pending; cpu_req has priority.
  - Walks index 0..SETS-1. Each valid+dirty line is written back as in WB. Every line is invalidated and its dirty bit cleared.
  - Ends with a flush_done pulse and a return to IDLE.
  - cpu_req is not serviced during FLUSH.
- Reset (asynchronous, any state):
  - All valid/dirty bits cleared; state goes to IDLE.
  - All outputs and counters go to 0.
  - Any in-flight memory transaction is abandoned; mem_req drops immediately.
  - Data array contents are not reset.

## Timing
- Request presented in cycle 0.
- Hit: cpu_ready in cycle 1.
- Clean miss, zero-wait memory: REFILL occupies cycles 1..LINE, IDLE re-lookup in cycle LINE+1, cpu_ready in cycle LINE+2 (6 for LINE=4).
- Dirty miss: add LINE cycles (10 for LINE=4).
- Each memory wait cycle adds 1 cycle.
- busy is registered: high from cycle 1 of a miss/flush until the cycle the FSM re-enters IDLE.
- Minimum spacing of back-to-back hits is 2 cycles.

## Test plan
- Reset: rst=0 mid-REFILL with mem_req=1 -> mem_req, busy, cpu_ready, and both counters read 0 immediately; a read of the same address afterwards misses.
- Cold read at 0x0000_0104, memory returning addr^0xA5A5A5A5 with zero wait -> reads of 0x100..0x10C; cpu_ready in cycle 6 with rdata 0xA5A5A4A1; miss_cnt=1.
- Write hit to 0x104 with sel=4'b0010, wdata=0x0000_BE00 -> cpu_ready in cycle 1; a subsequent read returns 0xA5A5BEA1; hit_cnt=2; no memory traffic.
- Conflict read at 0x104 + (SETS*LINE*4) -> 4 writes to 0x100..0x10C (data 0x100 word first) precede 4 reads; cpu_ready in cycle 10.
- Memory inserts 2 wait cycles per word on a clean miss -> mem_addr stable across the waits; cpu_ready in cycle 14.
- Dirty lines at indices 0 and 5, then flush -> exactly 8 memory writes in index order; flush_done pulses once; every following access misses.

Source files
------------

// File: rtl/dcache_param.sv
// rtl/dcache_param.sv - parametrised direct-mapped write-back, write-allocate data cache
// Register-based arrays with asynchronous read; word-serial memory port with per-word ack.
module dcache_param #(
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_sel,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        flush,
    output logic        busy,
    output logic        flush_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int SETS  = 1 << INDEX_W;
    localparam int LINE  = 1 << OFFSET_W;
    localparam int TAG_W = 30 - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL, S_FLUSH} state_t;

    state_t r_state, w_next;

    logic [OFFSET_W-1:0] r_word;
    logic [INDEX_W-1:0]  r_fidx;
    logic [SETS-1:0]     r_valid;
    logic [SETS-1:0]     r_dirty;
    logic [TAG_W-1:0]    r_tag  [SETS];
    logic [31:0]         r_data [SETS*LINE];

    logic        r_cpu_ready, r_busy, r_flush_done, r_flush_pend, r_refilled;
    logic [31:0] r_cpu_rdata, r_hit_cnt, r_miss_cnt;

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [OFFSET_W-1:0] w_woff;
    logic                w_cpu_act, w_hit, w_last, w_fl_dirty, w_fl_step;
    logic                w_unused;

    assign w_idx    = cpu_addr[OFFSET_W+2 +: INDEX_W];
    assign w_tag    = cpu_addr[31 -: TAG_W];
    assign w_woff   = cpu_addr[2 +: OFFSET_W];
    assign w_unused = ^cpu_addr[1:0];

    // The ready cycle still sees the held request; it must not be looked up again.
    assign w_cpu_act  = (r_state == S_IDLE) && cpu_req && !r_cpu_ready;
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_last     = &r_word;
    assign w_fl_dirty = r_valid[r_fidx] && r_dirty[r_fidx];
    assign w_fl_step  = (r_state == S_FLUSH) && (!w_fl_dirty || (mem_ack && w_last));

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_cpu_act) begin
                    if (!w_hit)
                        w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_REFILL;
                end else if (flush || r_flush_pend) begin
                    w_next = S_FLUSH;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag[w_idx], w_idx, r_word, 2'b00};
                mem_wdata = r_data[{w_idx, r_word}];
                if (mem_ack && w_last)
                    w_next = S_REFILL;
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_idx, r_word, 2'b00};
                if (mem_ack && w_last)
                    w_next = S_IDLE;
            end
            S_FLUSH: begin
                if (w_fl_dirty) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {r_tag[r_fidx], r_fidx, r_word, 2'b00};
                    mem_wdata = r_data[{r_fidx, r_word}];
                end
                if (w_fl_step && (&r_fidx))
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_word       <= '0;
            r_fidx       <= '0;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_cpu_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_flush_done <= 1'b0;
            r_flush_pend <= 1'b0;
            r_refilled   <= 1'b0;
            r_cpu_rdata  <= 32'd0;
            r_hit_cnt    <= 32'd0;
            r_miss_cnt   <= 32'd0;
        end else begin
            r_state      <= w_next;
            r_busy       <= (w_next != S_IDLE);
            r_cpu_ready  <= 1'b0;
            r_flush_done <= (r_state == S_FLUSH) && (w_next == S_IDLE);

            // A flush pulse that loses to a CPU request is remembered until accepted.
            if (flush)
                r_flush_pend <= 1'b1;
            if ((r_state == S_IDLE) && (w_next == S_FLUSH))
                r_flush_pend <= 1'b0;

            if ((r_state == S_REFILL) && (w_next == S_IDLE))
                r_refilled <= 1'b1;
            else if (r_state == S_IDLE)
                r_refilled <= 1'b0;

            if (w_cpu_act && w_hit) begin
                r_cpu_ready <= 1'b1;
                if (!cpu_we)
                    r_cpu_rdata <= r_data[{w_idx, w_woff}];
                else
                    r_dirty[w_idx] <= 1'b1;
                if (!r_refilled && (r_hit_cnt != 32'hFFFF_FFFF))
                    r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_cpu_act && !w_hit && (r_miss_cnt != 32'hFFFF_FFFF))
                r_miss_cnt <= r_miss_cnt + 32'd1;

            if (mem_req && mem_ack)
                r_word <= r_word + 1'b1;

            if ((r_state == S_REFILL) && mem_ack && w_last) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end

            if (w_fl_step) begin
                r_valid[r_fidx] <= 1'b0;
                r_dirty[r_fidx] <= 1'b0;
                r_fidx          <= r_fidx + 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if ((r_state == S_REFILL) && mem_ack) begin
            r_data[{w_idx, r_word}] <= mem_rdata;
            if (w_last)
                r_tag[w_idx] <= w_tag;
        end
        if (w_cpu_act && w_hit && cpu_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cpu_sel[b])
                    r_data[{w_idx, w_woff}][8*b +: 8] <= cpu_wdata[8*b +: 8];
            end
        end
    end

    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_ready  = r_cpu_ready;
    assign busy       = r_busy;
    assign flush_done = r_flush_done;
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_dcache_param.sv
// tb/tb_dcache_param.sv - scoreboard bench for dcache_param with a word-serial memory model
module tb_dcache_param;

    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, flush;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready, busy, flush_done;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] hit_cnt, miss_cnt;

    dcache_param #(.INDEX_W(6), .OFFSET_W(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .flush(flush), .busy(busy), .flush_done(flush_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        int          lat;
        int          t0;
    } cpu_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_op_t;

    cpu_exp_t cpu_q[$];
    mem_op_t  mem_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int mem_wait = 0;
    int n_mem_wr = 0;
    int fd_cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] data);
        mem_op_t e;
        e.we = we; e.addr = addr; e.data = data;
        mem_q.push_back(e);
    endtask

    task automatic push_line_reads(input logic [31:0] base);
        for (int w = 0; w < 4; w++) push_mem(1'b0, base + 32'(4*w), 32'd0);
    endtask

    task automatic cpu_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_lat);
        cpu_exp_t e;
        logic got;
        @(posedge clk); #1;
        e.rd = !we; e.data = exp_rd; e.lat = exp_lat; e.t0 = cyc;
        cpu_q.push_back(e);
        cpu_req = 1'b1; cpu_we = we; cpu_sel = sel; cpu_addr = addr; cpu_wdata = wd;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (cpu_ready) begin
                got = 1'b1;
                break;
            end
        end
        cpu_req = 1'b0;
        check("cpu_ready_seen", 32'(got), 32'd1);
        if (!got && cpu_q.size() > 0) cpu_q.delete(cpu_q.size() - 1);
    endtask

    // CPU response monitor
    initial begin
        forever begin
            @(posedge clk); #2;
            if (flush_done) fd_cnt++;
            if (cpu_ready) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_unexpected_ready", 32'(cpu_ready), 32'd0);
                end else begin
                    cpu_exp_t e;
                    e = cpu_q.pop_front();
                    check("cpu_latency", 32'(cyc - e.t0), 32'(e.lat));
                    if (e.rd) check("cpu_rdata", cpu_rdata, e.data);
                end
            end
        end
    end

    // Memory model and memory-traffic scoreboard
    initial begin
        int          wcnt;
        logic [31:0] held;
        mem_op_t     e;
        mem_ack = 1'b0; mem_rdata = 32'd0; wcnt = 0; held = 32'd0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (!mem_req || !rst) begin
                wcnt = 0;
            end else if (wcnt < mem_wait) begin
                if (wcnt == 0) held = mem_addr;
                wcnt++;
            end else begin
                if (mem_wait > 0) check("mem_addr_stable", mem_addr, held);
                wcnt = 0;
                mem_ack = 1'b1;
                mem_rdata = mem_we ? 32'd0 : (mem_addr ^ PAT);
                if (mem_we) n_mem_wr++;
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_op", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = mem_q.pop_front();
                    check("mem_we", 32'(mem_we), 32'(e.we));
                    check("mem_addr", mem_addr, e.addr);
                    if (e.we) check("mem_wdata", mem_wdata, e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_sel = 4'h0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        rst = 1'b1;

        // Cold read miss, zero-wait memory
        push_line_reads(32'h100);
        cpu_access(1'b0, 4'h0, 32'h104, 32'd0, 32'hA5A5_A4A1, 6);
        check("cold_miss_cnt", miss_cnt, 32'd1);
        check("cold_hit_cnt", hit_cnt, 32'd0);

        // Byte-lane write hit, then read back
        cpu_access(1'b1, 4'b0010, 32'h104, 32'h0000_BE00, 32'd0, 1);
        cpu_access(1'b0, 4'h0, 32'h104, 32'd0, 32'hA5A5_BEA1, 1);
        check("hit_cnt_after_hits", hit_cnt, 32'd2);
        check("miss_cnt_after_hits", miss_cnt, 32'd1);

        // Conflict miss on a dirty line: write-back then refill
        push_mem(1'b1, 32'h100, 32'hA5A5_A4A5);
        push_mem(1'b1, 32'h104, 32'hA5A5_BEA1);
        push_mem(1'b1, 32'h108, 32'hA5A5_A4AD);
        push_mem(1'b1, 32'h10C, 32'hA5A5_A4A9);
        push_line_reads(32'h500);
        cpu_access(1'b0, 4'h0, 32'h504, 32'd0, 32'hA5A5_A0A1, 10);
        check("dirty_miss_cnt", miss_cnt, 32'd2);
        check("dirty_hit_cnt", hit_cnt, 32'd2);

        // Clean miss with two wait cycles per word
        mem_wait = 2;
        push_line_reads(32'h200);
        cpu_access(1'b0, 4'h0, 32'h208, 32'd0, 32'hA5A5_A7AD, 14);
        mem_wait = 0;
        check("wait_miss_cnt", miss_cnt, 32'd3);

        // Dirty lines at index 0 and index 5
        push_line_reads(32'h000);
        cpu_access(1'b1, 4'hF, 32'h000, 32'h1111_1111, 32'd0, 6);
        push_line_reads(32'h050);
        cpu_access(1'b1, 4'hF, 32'h054, 32'h5555_5555, 32'd0, 6);
        check("pre_flush_miss_cnt", miss_cnt, 32'd5);

        // Flush: only the two dirty lines are written back, in index order
        push_mem(1'b1, 32'h000, 32'h1111_1111);
        push_mem(1'b1, 32'h004, 32'hA5A5_A5A1);
        push_mem(1'b1, 32'h008, 32'hA5A5_A5AD);
        push_mem(1'b1, 32'h00C, 32'hA5A5_A5A9);
        push_mem(1'b1, 32'h050, 32'hA5A5_A5F5);
        push_mem(1'b1, 32'h054, 32'h5555_5555);
        push_mem(1'b1, 32'h058, 32'hA5A5_A5FD);
        push_mem(1'b1, 32'h05C, 32'hA5A5_A5F9);
        n_mem_wr = 0; fd_cnt = 0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd1);
        for (k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            if (fd_cnt > 0) break;
        end
        repeat (4) @(posedge clk);
        #1;
        check("flush_done_pulses", 32'(fd_cnt), 32'd1);
        check("flush_mem_writes", 32'(n_mem_wr), 32'd8);
        check("flush_busy_end", 32'(busy), 32'd0);

        // Every line is invalid after flush
        push_line_reads(32'h500);
        cpu_access(1'b0, 4'h0, 32'h504, 32'd0, 32'hA5A5_A0A1, 6);
        push_line_reads(32'h000);
        cpu_access(1'b0, 4'h0, 32'h000, 32'd0, 32'hA5A5_A5A5, 6);
        check("post_flush_miss_cnt", miss_cnt, 32'd7);

        // Asynchronous reset in the middle of a refill
        push_mem(1'b0, 32'h300, 32'd0);
        push_mem(1'b0, 32'h304, 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h308;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("mem_req_before_reset", 32'(mem_req), 32'd1);
        rst = 1'b0; cpu_req = 1'b0;
        #1;
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cpu_ready", 32'(cpu_ready), 32'd0);
        check("reset_hit_cnt", hit_cnt, 32'd0);
        check("reset_miss_cnt", miss_cnt, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_line_reads(32'h300);
        cpu_access(1'b0, 4'h0, 32'h308, 32'd0, 32'hA5A5_A6AD, 6);
        check("after_reset_miss_cnt", miss_cnt, 32'd1);
        check("after_reset_hit_cnt", hit_cnt, 32'd0);

        repeat (4) @(posedge clk);
        #1;
        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
        check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
